// File: rtl/mux_tree_pipe_if.sv
// rtl/mux_tree_pipe_if.sv - handshake bundle for the pipelined N:1 selection tree
//
// Signals (widths from parameters W, N; L = log2(N)):
//   din       N*W  flat channel bus, channel k at [k*W+W-1 : k*W]
//   sel       L    channel index used in direct mode
//   mode      1    0 = direct select, 1 = auto-scan
//   in_valid  1    beat offered on din/sel
//   in_ready  1    beat accepted when in_valid && in_ready
//   dout      W    selected channel data
//   out_ch    L    channel index that produced dout
//   out_valid 1    dout/out_ch hold a valid beat
//   out_ready 1    downstream accepts when out_valid && out_ready
// Modports: master = upstream/downstream environment, slave = the tree.
interface mux_tree_pipe_if #(
  parameter int W = 8,
  parameter int N = 8
);
  localparam int L = $clog2(N);

  logic [N*W-1:0] din;
  logic [L-1:0]   sel;
  logic           mode;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   dout;
  logic [L-1:0]   out_ch;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output din, sel, mode, in_valid, out_ready,
    input  in_ready, dout, out_ch, out_valid
  );

  modport slave (
    input  din, sel, mode, in_valid, out_ready,
    output in_ready, dout, out_ch, out_valid
  );
endinterface

// File: rtl/mux_tree_pipe.sv
// rtl/mux_tree_pipe.sv - N:1 channel selection built as an L-level 2:1 tree with valid/ready flow
//
// Parameters: W (data width, >= 1), N (channel count, power of two, >= 2).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mux_tree_pipe_if.slave (din, sel, mode, in_valid, in_ready,
//          dout, out_ch, out_valid, out_ready)
// Configuration macro MUX_TREE_PIPE_STAGE_EN:
//   defined   -> every tree level is registered, latency = log2(N)
//   undefined -> combinational tree plus one output register, latency = 1
module mux_tree_pipe #(
  parameter int W = 8,
  parameter int N = 8
) (
  input logic           clk,
  input logic           rst_n,
  mux_tree_pipe_if.slave bus
);
  localparam int L = $clog2(N);

  logic         stall;
  logic         accept;
  logic [L-1:0] scan_cnt;
  logic [L-1:0] idx_in;

  // The whole pipeline freezes as one unit whenever the output is blocked,
  // so upstream acceptance depends only on the last stage.
  assign stall        = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready = ~stall;
  assign accept       = bus.in_valid & ~stall;
  assign idx_in       = bus.mode ? scan_cnt : bus.sel;

  // N is a power of two, so the natural L-bit rollover gives the N-1 -> 0 wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
    end else if (!stall) begin
      if (!bus.mode) begin
        scan_cnt <= '0;
      end else if (bus.in_valid) begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

  // Level l holds N>>l candidate channels. Level 0 is the raw input; each
  // later level halves the candidates using index bit l-1 of the beat's own
  // index, so the index travels with the data through the tree.
  for (genvar l = 0; l <= L; l++) begin : g_lvl
    localparam int CH = N >> l;

    logic [CH*W-1:0] d;
    logic [L-1:0]    idx;
    logic            vld;

    if (l == 0) begin : g_src
      assign d   = bus.din;
      assign idx = idx_in;
      assign vld = accept;
    end else begin : g_node
      logic [CH*W-1:0] mux;

      always_comb begin
        mux = '0;
        for (int j = 0; j < CH; j++) begin
          mux[j*W +: W] = g_lvl[l-1].idx[l-1] ? g_lvl[l-1].d[(2*j+1)*W +: W]
                                              : g_lvl[l-1].d[(2*j)*W +: W];
        end
      end

`ifdef MUX_TREE_PIPE_STAGE_EN
      // Every level is a pipeline stage; a bubble simply carries vld=0.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          d   <= '0;
          idx <= '0;
          vld <= 1'b0;
        end else if (!stall) begin
          d   <= mux;
          idx <= g_lvl[l-1].idx;
          vld <= g_lvl[l-1].vld;
        end
      end
`else
      if (l == L) begin : g_out_reg
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            d   <= '0;
            idx <= '0;
            vld <= 1'b0;
          end else if (!stall) begin
            d   <= mux;
            idx <= g_lvl[l-1].idx;
            vld <= g_lvl[l-1].vld;
          end
        end
      end else begin : g_comb
        assign d   = mux;
        assign idx = g_lvl[l-1].idx;
        assign vld = g_lvl[l-1].vld;
      end
`endif
    end
  end

  assign bus.dout      = g_lvl[L].d;
  assign bus.out_ch    = g_lvl[L].idx;
  assign bus.out_valid = g_lvl[L].vld;
endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb/tb_mux_tree_pipe.sv - self-checking bench for mux_tree_pipe (N=8, W=8)
module tb_mux_tree_pipe;
  localparam int W = 8;
  localparam int N = 8;
  localparam int L = 3;
`ifdef MUX_TREE_PIPE_STAGE_EN
  localparam int LAT = L;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [W-1:0] d;
    logic [L-1:0] ch;
    int           cyc;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   scan_m = 0;
  beat_t exp_q[$];
  beat_t obs_q[$];

  always #5 clk = ~clk;

  mux_tree_pipe_if #(.W(W), .N(N)) bus ();

  mux_tree_pipe #(.W(W), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: every accepted beat picks din[index] with index = sel or
  // the scan position; the scan position advances per accepted scan beat and
  // returns to 0 in direct mode, frozen while the output is blocked.
  always @(negedge clk) begin
    beat_t b;
    int    idx;
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        b.d = bus.dout; b.ch = bus.out_ch; b.cyc = cyc;
        obs_q.push_back(b);
      end
      if (bus.in_valid && bus.in_ready) begin
        idx = bus.mode ? scan_m : int'(bus.sel);
        b.d = bus.din[idx*W +: W]; b.ch = L'(idx); b.cyc = cyc;
        exp_q.push_back(b);
      end
      if (!(bus.out_valid && !bus.out_ready)) begin
        if (!bus.mode) scan_m <= 0;
        else if (bus.in_valid) scan_m <= (scan_m + 1) % N;
      end
    end else begin
      scan_m <= 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic default_din();
    for (int k = 0; k < N; k++) bus.din[k*W +: W] = W'(8'h10 + k);
  endtask

  task automatic clear_q();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
    vectors++; if (bus.dout !== 8'h00) begin miscompares++; $display("FAIL reset_dout: got %0h expected 0", bus.dout); end
    vectors++; if (bus.out_ch !== 3'd0) begin miscompares++; $display("FAIL reset_out_ch: got %0d expected 0", bus.out_ch); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %0b expected 1", bus.in_ready); end
  endtask

  task automatic test_direct();
    int vcount = 0;
    clear_q();
    bus.mode = 1'b0; bus.sel = 3'd5; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.sel = 3'd2;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      if (bus.out_valid) vcount++;
      tick();
    end
    vectors++; if (vcount !== 1) begin miscompares++; $display("FAIL direct_valid_cycles: got %0d expected 1", vcount); end
    vectors++; if (obs_q.size() !== 1) begin miscompares++; $display("FAIL direct_count: got %0d expected 1", obs_q.size()); end
    if (obs_q.size() == 1 && exp_q.size() == 1) begin
      vectors++; if (obs_q[0].d !== 8'h15) begin miscompares++; $display("FAIL direct_dout: got %0h expected 15", obs_q[0].d); end
      vectors++; if (obs_q[0].ch !== 3'd5) begin miscompares++; $display("FAIL direct_ch: got %0d expected 5", obs_q[0].ch); end
      vectors++; if (obs_q[0].cyc - exp_q[0].cyc !== LAT) begin miscompares++; $display("FAIL direct_latency: got %0d expected %0d", obs_q[0].cyc - exp_q[0].cyc, LAT); end
    end
  endtask

  task automatic test_scan();
    clear_q();
    bus.mode = 1'b1; bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1; bus.sel = 3'($urandom_range(0, 7));
      tick();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < LAT + 3; i++) tick();
    bus.mode = 1'b0;
    tick();
    vectors++; if (obs_q.size() !== 10) begin miscompares++; $display("FAIL scan_count: got %0d expected 10", obs_q.size()); end
    if (obs_q.size() == 10 && exp_q.size() == 10) begin
      for (int i = 0; i < 10; i++) begin
        vectors++; if (obs_q[i].ch !== 3'(i % 8)) begin miscompares++; $display("FAIL scan_ch[%0d]: got %0d expected %0d", i, obs_q[i].ch, i % 8); end
        vectors++; if (obs_q[i].d !== 8'(8'h10 + i % 8)) begin miscompares++; $display("FAIL scan_dout[%0d]: got %0h expected %0h", i, obs_q[i].d, 8'h10 + i % 8); end
        vectors++; if (obs_q[i].cyc - exp_q[i].cyc !== LAT) begin miscompares++; $display("FAIL scan_latency[%0d]: got %0d expected %0d", i, obs_q[i].cyc - exp_q[i].cyc, LAT); end
        if (i > 0) begin
          vectors++; if (obs_q[i].cyc - obs_q[i-1].cyc !== 1) begin miscompares++; $display("FAIL scan_throughput[%0d]: gap %0d expected 1", i, obs_q[i].cyc - obs_q[i-1].cyc); end
        end
      end
    end
  endtask

  task automatic test_stall();
    int  k = 0;
    int  first_seen = -1;
    int  stall_cycles = 0;
    logic acc;
    clear_q();
    bus.mode = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (first_seen < 0 && bus.out_valid) first_seen = t;
      bus.out_ready = !(first_seen >= 0 && t < first_seen + 4);
      bus.in_valid = (k < 8);
      bus.sel = 3'(k % 8);
      @(negedge clk);
      if (!bus.out_ready) begin
        stall_cycles++;
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready t=%0d: got %0b expected 0", t, bus.in_ready); end
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL stall_out_valid t=%0d: got %0b expected 1", t, bus.out_valid); end
        vectors++; if (bus.dout !== 8'h10) begin miscompares++; $display("FAIL stall_dout t=%0d: got %0h expected 10", t, bus.dout); end
      end
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) k++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    vectors++; if (stall_cycles !== 4) begin miscompares++; $display("FAIL stall_window: got %0d cycles expected 4", stall_cycles); end
    vectors++; if (obs_q.size() !== 8) begin miscompares++; $display("FAIL stall_count: got %0d expected 8", obs_q.size()); end
    if (obs_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        vectors++; if (obs_q[i].d !== 8'(8'h10 + i) || obs_q[i].ch !== 3'(i)) begin miscompares++; $display("FAIL stall_order[%0d]: got %0h/%0d expected %0h/%0d", i, obs_q[i].d, obs_q[i].ch, 8'h10 + i, i); end
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    bus.mode = 1'b1; bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; tick();
    bus.in_valid = 1'b1; tick();
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid: got %0b expected 0", bus.out_valid); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready: got %0b expected 1", bus.in_ready); end
    vectors++; if (bus.dout !== 8'h00 || bus.out_ch !== 3'd0) begin miscompares++; $display("FAIL midrst_outputs: got %0h/%0d expected 0/0", bus.dout, bus.out_ch); end
    tick(); tick();
    rst_n = 1'b1;
    clear_q();
    for (int i = 0; i < 6; i++) tick();
    vectors++; if (obs_q.size() !== 0) begin miscompares++; $display("FAIL midrst_ghost_beats: got %0d expected 0", obs_q.size()); end
    bus.in_valid = 1'b1; tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < LAT + 3; i++) tick();
    bus.mode = 1'b0;
    vectors++; if (obs_q.size() !== 1) begin miscompares++; $display("FAIL midrst_count: got %0d expected 1", obs_q.size()); end
    if (obs_q.size() == 1 && exp_q.size() == 1) begin
      vectors++; if (obs_q[0].ch !== 3'd0 || obs_q[0].d !== 8'h10) begin miscompares++; $display("FAIL midrst_first: got %0h/%0d expected 10/0", obs_q[0].d, obs_q[0].ch); end
      vectors++; if (obs_q[0].cyc - exp_q[0].cyc !== LAT) begin miscompares++; $display("FAIL midrst_latency: got %0d expected %0d", obs_q[0].cyc - exp_q[0].cyc, LAT); end
    end
  endtask

  task automatic test_bubble();
    clear_q();
    bus.mode = 1'b0; bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.sel = 3'd3; tick();
    bus.in_valid = 1'b0; bus.sel = 3'd6; tick();
    bus.in_valid = 1'b1; bus.sel = 3'd6; tick();
    bus.in_valid = 1'b0; bus.sel = 3'd1;
    for (int i = 0; i < LAT + 3; i++) tick();
    vectors++; if (obs_q.size() !== 2) begin miscompares++; $display("FAIL bubble_count: got %0d expected 2", obs_q.size()); end
    if (obs_q.size() == 2 && exp_q.size() == 2) begin
      vectors++; if (obs_q[0].d !== 8'h13 || obs_q[0].ch !== 3'd3) begin miscompares++; $display("FAIL bubble_first: got %0h/%0d expected 13/3", obs_q[0].d, obs_q[0].ch); end
      vectors++; if (obs_q[1].d !== 8'h16 || obs_q[1].ch !== 3'd6) begin miscompares++; $display("FAIL bubble_second: got %0h/%0d expected 16/6", obs_q[1].d, obs_q[1].ch); end
      vectors++; if (obs_q[1].cyc - obs_q[0].cyc !== 2) begin miscompares++; $display("FAIL bubble_gap: got %0d expected 2", obs_q[1].cyc - obs_q[0].cyc); end
      vectors++; if (obs_q[0].cyc - exp_q[0].cyc !== LAT) begin miscompares++; $display("FAIL bubble_latency: got %0d expected %0d", obs_q[0].cyc - exp_q[0].cyc, LAT); end
    end
  endtask

  task automatic test_random();
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_d = '0;
    logic [L-1:0] prev_ch = '0;
    clear_q();
    for (int t = 0; t < 1500; t++) begin
      for (int k = 0; k < N; k++) bus.din[k*W +: W] = W'($urandom);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.sel       = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) bus.mode = ~bus.mode;
      bus.out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      vectors++; if (bus.in_ready !== !(bus.out_valid && !bus.out_ready)) begin miscompares++; $display("FAIL rand_in_ready t=%0d: got %0b", t, bus.in_ready); end
      if (prev_stall) begin
        vectors++; if (bus.out_valid !== 1'b1 || bus.dout !== prev_d || bus.out_ch !== prev_ch) begin miscompares++; $display("FAIL rand_hold t=%0d: got %0b/%0h/%0d expected 1/%0h/%0d", t, bus.out_valid, bus.dout, bus.out_ch, prev_d, prev_ch); end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_d = bus.dout;
      prev_ch = bus.out_ch;
      tick();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int i = 0; i < LAT + 3; i++) tick();
    vectors++; if (obs_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL rand_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++; if (obs_q[i].d !== exp_q[i].d || obs_q[i].ch !== exp_q[i].ch) begin miscompares++; $display("FAIL rand_beat[%0d]: got %0h/%0d expected %0h/%0d", i, obs_q[i].d, obs_q[i].ch, exp_q[i].d, exp_q[i].ch); end
    end
    bus.mode = 1'b0;
    tick();
  endtask

  initial begin
    bus.din = '0; bus.sel = '0; bus.mode = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    default_din();
    #12;
    test_reset();
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    test_direct();
    test_scan();
    test_stall();
    test_reset_mid();
    test_bubble();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mux_tree_pipe.md
MUX_TREE_PIPE -- requirements
Module: mux_tree_pipe

Interface
REQ-001 Parameter W, default 8, data width per channel in bits, SHALL be at least 1.
REQ-002 Parameter N, default 8, channel count, SHALL be a power of two and at least 2; L = log2(N).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 din  input  N*W  flat channel bus; channel k occupies bits [k*W+W-1 : k*W].
REQ-006 sel  input  L  channel index used in direct mode.
REQ-007 mode  input  1  0 = direct select, 1 = auto-scan.
REQ-008 in_valid  input  1  beat offered on din/sel this cycle.
REQ-009 in_ready  output  1  beat accepted when in_valid and in_ready are both 1.
REQ-010 dout  output  W  selected channel data.
REQ-011 out_ch  output  L  channel index that produced dout.
REQ-012 out_valid  output  1  dout/out_ch hold a valid beat.
REQ-013 out_ready  input  1  downstream accepts the beat when out_valid and out_ready are both 1.

Function
REQ-014 The block SHALL implement an N:1 selection as an L-level tree of 2:1 selections, with sel bit 0 steering level 1 (leaf pairs) and sel bit L-1 steering the final level.
REQ-015 Effective index SHALL be sel when mode=0 and scan_cnt when mode=1; dout SHALL equal din channel[index] as sampled at acceptance, and out_ch SHALL equal that index.
REQ-016 scan_cnt (L bits) SHALL be held at 0 while mode=0 and, while mode=1, SHALL increment by 1 on each accepted beat, wrapping from N-1 to 0.
REQ-017 Stall SHALL be defined as out_valid=1 and out_ready=0; in_ready SHALL be the inverse of stall (combinational).
REQ-018 During stall, every pipeline register (data, index, valid) and scan_cnt SHALL hold its value.
REQ-019 When not stalled, every stage SHALL advance one position per cycle; a stage receiving no beat SHALL load valid=0 (bubble), and bubbles SHALL NOT be collapsed.
REQ-020 A beat accepted in cycle t with no later stall SHALL appear with out_valid=1 in cycle t+LAT (LAT per REQ-026/027).
REQ-021 Beats SHALL leave in acceptance order, with no loss or duplication; with out_ready held at 1, throughput SHALL be one beat per cycle.
REQ-022 Changing mode or sel while in_valid=0 SHALL have no effect on in-flight beats; a mode change on an accepted beat SHALL apply to that beat.
REQ-023 out_valid SHALL be able to fall while out_ready=0 only through reset.

Reset
REQ-024 On rst_n low, regardless of clk: all stage valid bits, out_valid, dout, out_ch and scan_cnt SHALL go to 0, and in_ready SHALL read 1.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight beats; the first beat accepted after release SHALL come out after LAT cycles, with scan starting at channel 0.

Configuration
REQ-026 With macro MUX_TREE_PIPE_STAGE_EN defined, each of the L tree levels SHALL be registered (data, index, valid), giving LAT = L (3 for N=8).
REQ-027 Without MUX_TREE_PIPE_STAGE_EN, the tree SHALL be combinational with a single output register, giving LAT = 1; all handshake, ordering and reset rules SHALL remain identical.

Verification (N=8, W=8; channel k data = 0x10+k unless stated otherwise)
REQ-028 mode=0, sel=5, one beat, out_ready=1 -> dout=0x15 and out_ch=5 exactly LAT cycles later, with out_valid high for one cycle.
REQ-029 mode=1, 10 consecutive beats, out_ready=1 -> out_ch sequence 0,1,...,7,0,1 with dout 0x10..0x17,0x10,0x11; one beat per cycle.
REQ-030 Stream of sel=0..7 with out_ready=0 for 4 cycles after the first output -> in_ready=0 during the stall, dout holds 0x10, and no beat is lost or repeated after release.
REQ-031 rst_n pulsed low mid-stream with 2 beats in flight -> out_valid=0 immediately, the in-flight beats never appear, and the next scan-mode beat returns out_ch=0.
REQ-032 Alternating in_valid 1/0 with sel=3,6 -> outputs 0x13 then 0x16, separated by one bubble cycle (out_valid=0).
REQ-033 Each scenario SHALL be run with and without MUX_TREE_PIPE_STAGE_EN; only latency SHALL differ (3 vs 1).
